// File: rtl/fxp_div_seq_pkg.sv
// Shared defaults for the signed Q(p).(f) divider: format widths, saturation codes and FSM states.
package fxp_div_seq_pkg;

    localparam int FXP_F = 10;
    localparam int FXP_P = 5;
    localparam int FXP_W = FXP_F + FXP_P + 1;

    localparam logic [FXP_W-1:0] FXP_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam logic [FXP_W-1:0] FXP_MIN = {1'b1, {(FXP_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_sat_sign.sv
// Unsigned N-bit magnitude plus sign -> saturated two's complement W-bit result.
module fxp_sat_sign #(
    parameter int W = 16,
    parameter int N = 26
) (
    input  logic [N-1:0] mag,
    input  logic         neg,
    output logic [W-1:0] y
);

    // Largest representable positive magnitude, and the one extra step allowed when negative.
    localparam logic [N-1:0] MAG_POS = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [N-1:0] MAG_NEG = MAG_POS + 1'b1;

    always_comb begin
        y = mag[W-1:0];
        if (!neg) begin
            if (mag > MAG_POS) y = {1'b0, {(W-1){1'b1}}};
        end else begin
            if (mag > MAG_NEG) y = {1'b1, {(W-1){1'b0}}};
            else               y = ~mag[W-1:0] + 1'b1;
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider Y = A / B, restoring division on magnitudes,
// one quotient bit per clock, saturating result, start/done handshake.
module fxp_div_seq
    import fxp_div_seq_pkg::*;
#(
    parameter  int F = FXP_F,
    parameter  int P = FXP_P,
    localparam int W = F + P + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output state_t       state_dbg
);

    // Handshake: A/B are taken on a rising edge where start=1 and busy=0; done pulses for
    // exactly one cycle with Y/div_zero valid, and start is already accepted in that cycle.
    localparam int N  = W + F;
    localparam int CW = $clog2(N);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W:0]     rem;
    logic [N-1:0]   nq;      // numerator bits shift out the top, quotient bits shift in the bottom
    logic [W-1:0]   mag_b;
    logic           neg;
    logic           a_neg;
    logic           b_zero;

    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_nx;
    logic           qbit;
    logic [W-1:0]   sat_y;

    always_comb begin
        abs_a  = A[W-1] ? (~A + 1'b1) : A;
        abs_b  = B[W-1] ? (~B + 1'b1) : B;
        rem_sh = (W+1)'({rem, nq[N-1]});
        qbit   = (rem_sh >= {1'b0, mag_b});
        rem_nx = qbit ? (rem_sh - {1'b0, mag_b}) : rem_sh;
    end

    fxp_sat_sign #(.W(W), .N(N)) u_sat (
        .mag (nq),
        .neg (neg),
        .y   (sat_y)
    );

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            nq       <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            a_neg    <= 1'b0;
            b_zero   <= 1'b0;
            Y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_CALC;
                        busy   <= 1'b1;
                        neg    <= A[W-1] ^ B[W-1];
                        a_neg  <= A[W-1];
                        b_zero <= (B == '0);
                        mag_b  <= abs_b;
                        rem    <= '0;
                        nq     <= {abs_a, {F{1'b0}}};
                        cnt    <= CW'(N - 1);
                    end
                end
                ST_CALC: begin
                    rem <= rem_nx;
                    nq  <= {nq[N-2:0], qbit};
                    if (cnt == '0) state <= ST_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= b_zero;
                    // Divide-by-zero saturates toward the dividend's sign (zero counts as positive).
                    if (b_zero) Y <= a_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    else        Y <= sat_y;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_div_seq.sv
// Scoreboard bench for fxp_div_seq at default Q5.10: directed vectors, ignored start,
// back-to-back start, and reset in the middle of an operation.
module tb_fxp_div_seq;
    import fxp_div_seq_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         div_zero;
    state_t       state_dbg;

    int cyc;
    int n_total;
    int n_pass;

    logic [W-1:0] exp_q[$];
    logic         exp_dz_q[$];
    int           exp_cyc_q[$];

    fxp_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .Y         (y),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // driver: one-cycle start pulse on a negedge; expected result pushed when push=1
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ey, input logic edz, input bit push);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(ey);
            exp_dz_q.push_back(edz);
            exp_cyc_q.push_back(cyc + 28);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        if (k == 200) check("wait_idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("y",        32'(y),        32'(exp_q.pop_front()));
                check("div_zero", 32'(div_zero), 32'(exp_dz_q.pop_front()));
                check("latency",  32'(cyc),      32'(exp_cyc_q.pop_front()));
            end
        end
    end

    // directed vectors with hand-computed quotients
    localparam int NV = 12;
    logic [W-1:0] va [NV] = '{16'h0C00, 16'h0400, 16'hFC00, 16'h4000, 16'hC000, 16'h8000,
                              16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0400, 16'hFC00};
    logic [W-1:0] vb [NV] = '{16'h0800, 16'h0C00, 16'h0C00, 16'h0080, 16'h0080, 16'hFC00,
                              16'h0400, 16'h0400, 16'h7FFF, 16'hFC00, 16'h0000, 16'h0000};
    logic [W-1:0] vy [NV] = '{16'h0600, 16'h0155, 16'hFEAB, 16'h7FFF, 16'h8000, 16'h7FFF,
                              16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
    logic         vdz[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int c0;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #12;
        check("rst_y",     32'(y),        32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_dz",    32'(div_zero), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vy[i], vdz[i], 1'b1);
            check("busy_after_accept", 32'(busy), 32'd1);
            wait_idle();
        end
        check("y_held", 32'(y), 32'h8000);

        // start pulsed mid-operation is ignored
        issue(16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        a = 16'h4000; b = 16'h0080; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high: second operands accepted in the done cycle
        c0 = cyc;
        a = 16'h0C00; b = 16'h0800; start = 1'b1;
        exp_q.push_back(16'h0600); exp_dz_q.push_back(1'b0); exp_cyc_q.push_back(c0 + 28);
        @(negedge clk);
        a = 16'hFC00; b = 16'h0000;
        exp_q.push_back(16'h8000); exp_dz_q.push_back(1'b1); exp_cyc_q.push_back(c0 + 56);
        repeat (28) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset in the middle of an operation: outputs clear, no done
        issue(16'h0C00, 16'h0800, 16'h0000, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_y",    32'(y),        32'd0);
        check("midrst_busy", 32'(busy),     32'd0);
        check("midrst_dz",   32'(div_zero), 32'd0);
        check("midrst_done", 32'(done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done_busy", 32'(busy), 32'd0);

        issue(16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b1);
        wait_idle();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
